// File: rtl/rs_dec_pkg.sv
// Shared constants and types for the RS(544,522) decoder back end.
package rs_dec_pkg;
  localparam int W     = 10;
  localparam int T     = 11;
  localparam int POS_W = 10;
  localparam int TAG_W = 4;
  localparam int DEG_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN,
    S_STATUS
  } sched_state_e;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
  } err_evt_t;
endpackage

// File: rtl/chien_forney_sched_if.sv
// Bundle of the RiBM, Chien/Forney, corrector and status links around the scheduler.
interface chien_forney_sched_if;
  import rs_dec_pkg::*;

  logic                 ribm_vld_i;
  logic                 ribm_rdy_o;
  logic [(T+1)*W-1:0]   ribm_sigma_i;
  logic [T*W-1:0]       ribm_v_i;
  logic [DEG_W-1:0]     ribm_deg_i;
  logic [TAG_W-1:0]     ribm_tag_i;
  logic                 csf_cfg_vld_o;
  logic [(T+1)*W-1:0]   csf_sigma_o;
  logic [T*W-1:0]       csf_v_o;
  logic                 csf_done_i;
  logic                 fny_vld_i;
  logic                 fny_rdy_o;
  logic [POS_W-1:0]     fny_pos_i;
  logic [W-1:0]         fny_y_i;
  logic                 fny_den_zero_i;
  logic                 err_vld_o;
  logic                 err_rdy_i;
  logic [POS_W-1:0]     err_pos_o;
  logic [W-1:0]         err_y_o;
  logic [TAG_W-1:0]     err_tag_o;
  logic                 stat_vld_o;
  logic                 stat_rdy_i;
  logic [TAG_W-1:0]     stat_tag_o;
  logic [CNT_W-1:0]     stat_cnt_o;
  logic                 stat_fail_o;

  modport slave (
    input  ribm_vld_i, ribm_sigma_i, ribm_v_i, ribm_deg_i, ribm_tag_i,
    input  csf_done_i, fny_vld_i, fny_pos_i, fny_y_i, fny_den_zero_i,
    input  err_rdy_i, stat_rdy_i,
    output ribm_rdy_o, csf_cfg_vld_o, csf_sigma_o, csf_v_o, fny_rdy_o,
    output err_vld_o, err_pos_o, err_y_o, err_tag_o,
    output stat_vld_o, stat_tag_o, stat_cnt_o, stat_fail_o
  );

  modport master (
    output ribm_vld_i, ribm_sigma_i, ribm_v_i, ribm_deg_i, ribm_tag_i,
    output csf_done_i, fny_vld_i, fny_pos_i, fny_y_i, fny_den_zero_i,
    output err_rdy_i, stat_rdy_i,
    input  ribm_rdy_o, csf_cfg_vld_o, csf_sigma_o, csf_v_o, fny_rdy_o,
    input  err_vld_o, err_pos_o, err_y_o, err_tag_o,
    input  stat_vld_o, stat_tag_o, stat_cnt_o, stat_fail_o
  );
endinterface

// File: rtl/err_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs; ready depends only on state.
module err_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_vld_i,
  output logic          in_rdy_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_vld_o,
  input  logic          out_rdy_i,
  output logic [DW-1:0] out_data_o,
  output logic          empty_o
);
  logic          main_vld_q, main_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_fire, out_fire;

  assign in_rdy_o   = !skid_vld_q;
  assign in_fire    = in_vld_i && !skid_vld_q;
  assign out_fire   = main_vld_q && out_rdy_i;
  assign out_vld_o  = main_vld_q;
  assign out_data_o = main_q;
  assign empty_o    = !main_vld_q && !skid_vld_q;

  // The skid slot only fills while the output register is stalled.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
endmodule

// File: rtl/chien_forney_sched.sv
// Frame scheduler: launches chien_search_forney once per RiBM result, forwards
// Forney error events to the corrector and reports per-frame status.
module chien_forney_sched
  import rs_dec_pkg::*;
#(
  parameter int DRAIN_CYC   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  chien_forney_sched_if.slave  bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int QW    = $clog2(DRAIN_CYC + 1);

  sched_state_e         state_q, state_d;
  logic [(T+1)*W-1:0]   sigma_q, sigma_d;
  logic [T*W-1:0]       v_q, v_d;
  logic [DEG_W-1:0]     deg_q, deg_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fail_q, fail_d;
  logic                 rdy_q, rdy_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [QW-1:0]        quiet_q, quiet_d;
  logic                 buf_in_rdy, buf_empty, evt_acc;
  err_evt_t             evt_in, evt_out;

  assign bus.fny_rdy_o = ((state_q == S_RUN) || (state_q == S_DRAIN)) && buf_in_rdy;
  assign evt_acc       = bus.fny_vld_i && bus.fny_rdy_o;
  assign evt_in        = '{pos: bus.fny_pos_i, y: bus.fny_y_i, tag: tag_q};

  err_skid_buf #(.DW($bits(err_evt_t))) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_vld_i   (evt_acc),
    .in_rdy_o   (buf_in_rdy),
    .in_data_i  (evt_in),
    .out_vld_o  (bus.err_vld_o),
    .out_rdy_i  (bus.err_rdy_i),
    .out_data_o (evt_out),
    .empty_o    (buf_empty)
  );

  assign bus.err_pos_o     = evt_out.pos;
  assign bus.err_y_o       = evt_out.y;
  assign bus.err_tag_o     = evt_out.tag;
  assign bus.ribm_rdy_o    = rdy_q;
  assign bus.csf_cfg_vld_o = (state_q == S_LAUNCH);
  assign bus.csf_sigma_o   = sigma_q;
  assign bus.csf_v_o       = v_q;
  assign bus.stat_vld_o    = (state_q == S_STATUS);
  assign bus.stat_tag_o    = tag_q;
  assign bus.stat_cnt_o    = cnt_q;
  assign bus.stat_fail_o   = fail_q;

  always_comb begin
    state_d = state_q;
    sigma_d = sigma_q;
    v_d     = v_q;
    deg_d   = deg_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    quiet_d = quiet_q;

    if (evt_acc) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (bus.fny_den_zero_i) fail_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.ribm_vld_i && rdy_q) begin
          sigma_d = bus.ribm_sigma_i;
          v_d     = bus.ribm_v_i;
          deg_d   = bus.ribm_deg_i;
          tag_d   = bus.ribm_tag_i;
          cnt_d   = '0;
          fail_d  = 1'b0;
          if (bus.ribm_deg_i == '0) begin
            state_d = S_STATUS;
          end else if (bus.ribm_deg_i > DEG_W'(T)) begin
            fail_d  = 1'b1;
            state_d = S_STATUS;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (bus.csf_done_i) begin
          quiet_d = '0;
          state_d = S_DRAIN;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          fail_d  = 1'b1;
          quiet_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Close only after a quiet window with every event handed to the corrector.
        if (evt_acc) begin
          quiet_d = '0;
        end else if (quiet_q != QW'(DRAIN_CYC)) begin
          quiet_d = quiet_q + 1'b1;
        end else if (buf_empty) begin
          if (cnt_q != deg_q) fail_d = 1'b1;
          state_d = S_STATUS;
        end
      end
      S_STATUS: begin
        if (bus.stat_rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy_d = (state_d == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sigma_q <= '0;
      v_q     <= '0;
      deg_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      rdy_q   <= 1'b0;
      timer_q <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      sigma_q <= sigma_d;
      v_q     <= v_d;
      deg_q   <= deg_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      rdy_q   <= rdy_d;
      timer_q <= timer_d;
      quiet_q <= quiet_d;
    end
  end
endmodule

// File: tb/tb_chien_forney_sched.sv
// Scoreboard bench for chien_forney_sched: frames are driven, expected error
// events and status words are queued and matched as the scheduler emits them.
module tb_chien_forney_sched;
  import rs_dec_pkg::*;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
    logic             fail;
  } stat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   toggleMode = 1'b0;
  bit   sawBp = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   launchCnt = 0;
  int   posTab[$];
  err_evt_t errQ[$];
  stat_t    statQ[$];

  chien_forney_sched_if bus ();

  chien_forney_sched dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (toggleMode) bus.err_rdy_i = ~bus.err_rdy_i;
    else            bus.err_rdy_i = 1'b1;
  end

  always @(negedge clk) begin
    if (bus.csf_cfg_vld_o === 1'b1) launchCnt++;
    if (bus.err_vld_o === 1'b1 && bus.err_rdy_i === 1'b1) begin
      checkOutput("err_expected", (errQ.size() != 0), 1);
      if (errQ.size() != 0) begin
        err_evt_t e;
        e = errQ.pop_front();
        checkOutput("err_event", {bus.err_pos_o, bus.err_y_o, bus.err_tag_o}, e);
      end
    end
    if (bus.stat_vld_o === 1'b1 && bus.stat_rdy_i === 1'b1) begin
      checkOutput("stat_expected", (statQ.size() != 0), 1);
      if (statQ.size() != 0) begin
        stat_t s;
        s = statQ.pop_front();
        checkOutput("stat_word", {bus.stat_tag_o, bus.stat_cnt_o, bus.stat_fail_o}, s);
      end
    end
  end

  task automatic checkAllZero(input string name);
    checkOutput(name, {bus.ribm_rdy_o, bus.csf_cfg_vld_o, bus.fny_rdy_o, bus.err_vld_o,
                       bus.stat_vld_o, bus.stat_fail_o, bus.stat_cnt_o, bus.stat_tag_o,
                       bus.err_pos_o, bus.err_y_o, bus.err_tag_o}, 0);
    checkOutput({name, "_sigma"}, bus.csf_sigma_o, 0);
  endtask

  // Hands one RiBM result over; returns the launch-check values driven.
  task automatic sendRibm(input logic [3:0] deg, input logic [3:0] tag,
                          output logic [(T+1)*W-1:0] sig, output logic [T*W-1:0] vv);
    logic [127:0] tmp;
    bit ok;
    tmp = {$urandom, $urandom, $urandom, $urandom};
    sig = tmp[(T+1)*W-1:0];
    tmp = {$urandom, $urandom, $urandom, $urandom};
    vv  = tmp[T*W-1:0];
    @(posedge clk); #1;
    bus.ribm_vld_i   = 1'b1;
    bus.ribm_sigma_i = sig;
    bus.ribm_v_i     = vv;
    bus.ribm_deg_i   = deg;
    bus.ribm_tag_i   = tag;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.ribm_rdy_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checkOutput("ribm_accepted", ok, 1);
    @(posedge clk); #1;
    bus.ribm_vld_i = 1'b0;
  endtask

  task automatic waitLaunch(input logic [(T+1)*W-1:0] sig, input logic [T*W-1:0] vv);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.csf_cfg_vld_o === 1'b1) begin seen = 1'b1; break; end
    end
    checkOutput("launch_seen", seen, 1);
    checkOutput("launch_sigma", bus.csf_sigma_o, sig);
    checkOutput("launch_v", bus.csf_v_o, vv);
  endtask

  task automatic sendEvents(input int nEvt, input logic [15:0] dzMask, input bit doDone,
                            input logic [3:0] tag);
    bit acc;
    @(posedge clk); #1;
    for (int i = 0; i < nEvt; i++) begin
      bus.fny_vld_i      = 1'b1;
      bus.fny_pos_i      = POS_W'((i < posTab.size()) ? posTab[i] : $urandom_range(0, 543));
      bus.fny_y_i        = W'($urandom_range(1, 1023));
      bus.fny_den_zero_i = dzMask[i];
      bus.csf_done_i     = doDone && (i == nEvt - 1);
      acc = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (bus.fny_rdy_o === 1'b1) begin
          acc = 1'b1;
          errQ.push_back('{pos: bus.fny_pos_i, y: bus.fny_y_i, tag: tag});
        end else begin
          sawBp = 1'b1;
        end
        @(posedge clk); #1;
        bus.csf_done_i = 1'b0;
        if (acc) break;
      end
      checkOutput("event_accepted", acc, 1);
    end
    bus.fny_vld_i      = 1'b0;
    bus.fny_den_zero_i = 1'b0;
    if (doDone && nEvt == 0) begin
      bus.csf_done_i = 1'b1;
      @(posedge clk); #1;
      bus.csf_done_i = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] deg, input logic [3:0] tag, input int nEvt,
                               input logic [15:0] dzMask, input bit doDone);
    logic [(T+1)*W-1:0] sig;
    logic [T*W-1:0]     vv;
    bit    inRange, dz, seen;
    int    expCnt, lat, launch0;
    stat_t s;
    inRange = (deg != 0) && (deg <= 4'(T));
    expCnt  = inRange ? ((nEvt > 15) ? 15 : nEvt) : 0;
    dz = 1'b0;
    for (int i = 0; i < nEvt; i++) dz |= dzMask[i];
    s.tag  = tag;
    s.cnt  = 4'(expCnt);
    s.fail = (deg > 4'(T)) || (inRange && (dz || !doDone || (expCnt != int'(deg))));
    statQ.push_back(s);
    launch0 = launchCnt;
    sendRibm(deg, tag, sig, vv);
    if (inRange) begin
      waitLaunch(sig, vv);
      sendEvents(nEvt, dzMask, doDone, tag);
    end
    seen = 1'b0;
    for (lat = 1; lat < 1300; lat++) begin
      @(negedge clk);
      if (bus.stat_vld_o === 1'b1) begin seen = 1'b1; break; end
    end
    checkOutput("status_seen", seen, 1);
    if (!inRange) checkOutput("status_fast", (lat <= 2), 1);
    @(posedge clk); #1;
    checkOutput("launch_count", launchCnt - launch0, inRange ? 1 : 0);
  endtask

  initial begin
    logic [(T+1)*W-1:0] sig;
    logic [T*W-1:0]     vv;
    bus.ribm_vld_i = 0; bus.ribm_sigma_i = '0; bus.ribm_v_i = '0;
    bus.ribm_deg_i = '0; bus.ribm_tag_i = '0; bus.csf_done_i = 0;
    bus.fny_vld_i = 0; bus.fny_pos_i = '0; bus.fny_y_i = '0;
    bus.fny_den_zero_i = 0; bus.stat_rdy_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_reset_0", bus.ribm_rdy_o, 0);
    @(negedge clk);
    checkOutput("rdy_after_reset_1", bus.ribm_rdy_o, 1);

    $display("[TB] frame: 4 errors, done with last event");
    posTab = '{17, 102, 300, 511};
    applyStimulus(4'd4, 4'd9, 4, 16'h0, 1'b1);
    posTab = {};

    $display("[TB] idle events ignored, then deg=0 frame");
    @(posedge clk); #1;
    bus.fny_vld_i = 1'b1;
    @(negedge clk);
    checkOutput("idle_fny_rdy", bus.fny_rdy_o, 0);
    @(posedge clk); #1;
    bus.fny_vld_i = 1'b0;
    applyStimulus(4'd0, 4'd3, 0, 16'h0, 1'b0);

    $display("[TB] frame: deg=3 with only 2 events");
    applyStimulus(4'd3, 4'd6, 2, 16'h0, 1'b1);

    $display("[TB] frame: 11 events with toggling corrector ready");
    toggleMode = 1'b1;
    sawBp = 1'b0;
    applyStimulus(4'd11, 4'd10, 11, 16'h0, 1'b1);
    checkOutput("fny_backpressure", sawBp, 1);
    toggleMode = 1'b0;

    $display("[TB] frame: den_zero on 2nd event, no done (timeout)");
    applyStimulus(4'd2, 4'd12, 2, 16'h2, 1'b0);

    $display("[TB] frame: deg beyond T");
    applyStimulus(4'd13, 4'd1, 0, 16'h0, 1'b0);

    $display("[TB] reset during RUN after one event");
    sendRibm(4'd3, 4'd5, sig, vv);
    waitLaunch(sig, vv);
    sendEvents(1, 16'h0, 1'b0, 4'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("midrun_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(4'd2, 4'd7, 2, 16'h0, 1'b1);

    repeat (20) @(posedge clk);
    checkOutput("err_queue_drained", errQ.size(), 0);
    checkOutput("stat_queue_drained", statQ.size(), 0);
    checkOutput("total_launches", launchCnt, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end
endmodule
